uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 568 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling, FSM states, stop/parity constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int STOP_ONE = 1;
  localparam int STOP_TWO = 2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 16x clock, holding + shift register for
// back-to-back frames, optional parity, one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] DATAin,
  input  logic       WriteSignal,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic STOP_LAST =
    (STOP_BITS == STOP_ONE) ? 1'b0 : (STOP_BITS == STOP_TWO);
  localparam logic PAR_SENSE =
    (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic HAS_PAR = (PARITY_EN != 0);

  state_e     state_q;
  logic [3:0] tick_q;
  logic [2:0] idx_q;
  logic       stop_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic       tx_q;
  logic       done_q;

  logic bit_end;
  logic frame_end;
  logic wr_acc;
  logic start_frame;
  logic par_d;

  assign bit_end   = (tick_q == TICK_LAST);
  assign frame_end = (state_q == ST_STOP) && bit_end
                   && (stop_q == STOP_LAST);
  assign wr_acc    = WriteSignal && !hold_full_q;
  assign start_frame = hold_full_q
                     && ((state_q == ST_IDLE) || frame_end);
  assign par_d     = (^hold_q) ^ PAR_SENSE;

  assign ready = !hold_full_q;
  assign busy  = (state_q != ST_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      // Tick wraps 15 -> 0 on its own at each bit boundary.
      if (state_q != ST_IDLE) tick_q <= tick_q + 4'd1;

      unique case (state_q)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              if (HAS_PAR) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_q == STOP_LAST) state_q <= ST_IDLE;
            else stop_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Transfer beats the case above; a write can never coincide
      // with it because the holding register is full then.
      if (start_frame) begin
        state_q     <= ST_START;
        tick_q      <= '0;
        tx_q        <= 1'b0;
        shift_q     <= hold_q;
        par_q       <= par_d;
        hold_full_q <= 1'b0;
      end else if (wr_acc) begin
        hold_q      <= DATAin;
        hold_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations, frame-level reference
// model, per-clock waveform checks and a behavioural loopback receiver.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int SB [3] = '{1, 1, 2};
  localparam int NLB  = 256;
  localparam int CAPN = 2048;

  logic       clock;
  logic       reset_n;
  logic [2:0] wr;
  logic [7:0] din [3];
  wire  [2:0] rdy, txl, bsy, dn;

  int tests;
  int fails;

  logic exp_bit  [128];
  int   exp_nbits;
  logic exp_done [CAPN];
  logic cap_tx   [CAPN];
  logic cap_done [CAPN];
  logic cap_busy [CAPN];
  logic cap_rdy  [CAPN];

  uart_tx #(.PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0]))
  u_tx0 (.clock(clock), .reset_n(reset_n), .DATAin(din[0]),
    .WriteSignal(wr[0]), .ready(rdy[0]), .tx(txl[0]),
    .busy(bsy[0]), .done(dn[0]));

  uart_tx #(.PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1]))
  u_tx1 (.clock(clock), .reset_n(reset_n), .DATAin(din[1]),
    .WriteSignal(wr[1]), .ready(rdy[1]), .tx(txl[1]),
    .busy(bsy[1]), .done(dn[1]));

  uart_tx #(.PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2]))
  u_tx2 (.clock(clock), .reset_n(reset_n), .DATAin(din[2]),
    .WriteSignal(wr[2]), .ready(rdy[2]), .tx(txl[2]),
    .busy(bsy[2]), .done(dn[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: a frame is a list of line levels, one per bit.
  task automatic model_clear();
    exp_nbits = 0;
    for (int i = 0; i < CAPN; i++) exp_done[i] = 1'b0;
  endtask

  task automatic model_frame(input int k, input logic [7:0] d);
    int ones = 0;
    exp_bit[exp_nbits] = 1'b0;
    exp_nbits++;
    for (int i = 0; i < 8; i++) begin
      exp_bit[exp_nbits] = d[i];
      exp_nbits++;
      ones += int'(d[i]);
    end
    if (PE[k] != 0) begin
      exp_bit[exp_nbits] = 1'(((ones % 2) + PO[k]) % 2);
      exp_nbits++;
    end
    for (int s = 0; s < SB[k]; s++) begin
      exp_bit[exp_nbits] = 1'b1;
      exp_nbits++;
    end
    exp_done[exp_nbits * OVERSAMPLE] = 1'b1;
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_bit[exp_nbits] = 1'b1;
      exp_nbits++;
    end
  endtask

  task automatic capture(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cap_tx[i]   = txl[k];
      cap_done[i] = dn[k];
      cap_busy[i] = bsy[k];
      cap_rdy[i]  = rdy[k];
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic write_now(input int k, input logic [7:0] d);
    wr[k]  = 1'b1;
    din[k] = d;
    @(posedge clock);
    #1;
    wr[k]  = 1'b0;
    din[k] = 8'($urandom);
  endtask

  task automatic wait_ready(input int k, input int lim, output logic ok);
    int w = 0;
    while (rdy[k] !== 1'b1 && w < lim) begin
      @(posedge clock);
      #1;
      w++;
    end
    ok = (rdy[k] === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (txl[k] !== 1'b1) begin
        fails++;
        $display("FAIL reset_tx[%0d]: got %b want 1", k, txl[k]);
      end
      tests++;
      if (rdy[k] !== 1'b1) begin
        fails++;
        $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]);
      end
      tests++;
      if (bsy[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_busy[%0d]: got %b want 0", k, bsy[k]);
      end
      tests++;
      if (dn[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_done[%0d]: got %b want 0", k, dn[k]);
      end
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    begin
      int nbad = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (txl !== 3'b111 || bsy !== 3'b000) nbad++;
      end
      tests++;
      if (nbad != 0) begin
        fails++;
        $display("FAIL reset_quiet: %0d clocks active, want 0", nbad);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_frame_55();
    int n;
    int nbad = 0;
    int fb = 0;
    model_clear();
    model_frame(0, 8'h55);
    n = exp_nbits * OVERSAMPLE + 1;
    write_now(0, 8'h55);
    tests++;
    if (rdy[0] !== 1'b0) begin
      fails++;
      $display("FAIL f55_ready_after_write: got %b want 0", rdy[0]);
    end
    tests++;
    if (txl[0] !== 1'b1) begin
      fails++;
      $display("FAIL f55_tx_early: got %b want 1", txl[0]);
    end
    @(posedge clock);
    capture(0, n);
    for (int b = 0; b < exp_nbits; b++)
      for (int c = 0; c < OVERSAMPLE; c++)
        if (cap_tx[16*b+c] !== exp_bit[b]) begin
          if (nbad == 0) fb = 16*b + c;
          nbad++;
        end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL f55_tx: %0d clocks wrong, first clock %0d tx=%b want %b",
        nbad, fb, cap_tx[fb], exp_bit[fb/16]);
    end
    nbad = 0;
    for (int i = 0; i < n; i++)
      if (cap_done[i] !== exp_done[i]) begin
        if (nbad == 0) fb = i;
        nbad++;
      end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL f55_done: %0d clocks wrong, first clock %0d done=%b want %b",
        nbad, fb, cap_done[fb], exp_done[fb]);
    end
    tests++;
    if (cap_busy[0] !== 1'b1 || cap_rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL f55_start_flags: busy=%b ready=%b want 1 1",
        cap_busy[0], cap_rdy[0]);
    end
    tests++;
    if (cap_busy[160] !== 1'b0) begin
      fails++;
      $display("FAIL f55_busy_after: got %b want 0", cap_busy[160]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    int n;
    int nbad = 0;
    int fb = 0;
    model_clear();
    model_frame(0, 8'hA5);
    model_frame(0, 8'h3C);
    n = exp_nbits * OVERSAMPLE + 1;
    write_now(0, 8'hA5);
    fork
      begin
        @(posedge clock);
        capture(0, n);
      end
      begin
        repeat (20) begin @(posedge clock); #1; end
        write_now(0, 8'h3C);
      end
    join
    for (int b = 0; b < exp_nbits; b++)
      for (int c = 0; c < OVERSAMPLE; c++)
        if (cap_tx[16*b+c] !== exp_bit[b]) begin
          if (nbad == 0) fb = 16*b + c;
          nbad++;
        end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL b2b_tx: %0d clocks wrong, first clock %0d tx=%b want %b",
        nbad, fb, cap_tx[fb], exp_bit[fb/16]);
    end
    nbad = 0;
    for (int i = 0; i < n; i++)
      if (cap_done[i] !== exp_done[i]) begin
        if (nbad == 0) fb = i;
        nbad++;
      end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL b2b_done: %0d clocks wrong, first clock %0d done=%b want %b",
        nbad, fb, cap_done[fb], exp_done[fb]);
    end
    nbad = 0;
    for (int i = 0; i < 320; i++) if (cap_busy[i] !== 1'b1) nbad++;
    tests++;
    if (nbad != 0 || cap_busy[320] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_busy: %0d idle clocks in frames, end busy=%b want 0 0",
        nbad, cap_busy[320]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_parity();
    for (int k = 1; k < 3; k++) begin
      int n;
      int nbad = 0;
      int fb = 0;
      logic want_par;
      int want_len;
      want_par = (k == 1) ? 1'b1 : 1'b0;
      want_len = (k == 1) ? 176 : 192;
      model_clear();
      model_frame(k, 8'h07);
      n = exp_nbits * OVERSAMPLE + 1;
      write_now(k, 8'h07);
      @(posedge clock);
      capture(k, n);
      for (int b = 0; b < exp_nbits; b++)
        for (int c = 0; c < OVERSAMPLE; c++)
          if (cap_tx[16*b+c] !== exp_bit[b]) begin
            if (nbad == 0) fb = 16*b + c;
            nbad++;
          end
      tests++;
      if (nbad != 0) begin
        fails++;
        $display("FAIL par%0d_tx: %0d clocks wrong, first clock %0d tx=%b want %b",
          k, nbad, fb, cap_tx[fb], exp_bit[fb/16]);
      end
      tests++;
      if (cap_tx[16*9+8] !== want_par) begin
        fails++;
        $display("FAIL par%0d_bit: got %b want %b", k, cap_tx[16*9+8], want_par);
      end
      nbad = 0;
      for (int i = 0; i < n; i++)
        if (cap_done[i] !== exp_done[i]) nbad++;
      tests++;
      if (nbad != 0 || cap_done[want_len] !== 1'b1) begin
        fails++;
        $display("FAIL par%0d_len: %0d done errors, done@%0d=%b want 0 1",
          k, nbad, want_len, cap_done[want_len]);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_ignore_full();
    int n;
    int nbad = 0;
    int fb = 0;
    model_clear();
    model_frame(0, 8'h11);
    model_frame(0, 8'h22);
    model_idle(3);
    n = exp_nbits * OVERSAMPLE + 1;
    write_now(0, 8'h11);
    fork
      begin
        @(posedge clock);
        capture(0, n);
      end
      begin
        repeat (5) begin @(posedge clock); #1; end
        wr[0]  = 1'b1;
        din[0] = 8'h22;
        @(posedge clock);
        #1;
        tests++;
        if (rdy[0] !== 1'b0) begin
          fails++;
          $display("FAIL ign_ready: got %b want 0", rdy[0]);
        end
        din[0] = 8'h33;
        repeat (10) begin @(posedge clock); #1; end
        wr[0]  = 1'b0;
        din[0] = 8'($urandom);
      end
    join
    for (int b = 0; b < exp_nbits; b++)
      for (int c = 0; c < OVERSAMPLE; c++)
        if (cap_tx[16*b+c] !== exp_bit[b]) begin
          if (nbad == 0) fb = 16*b + c;
          nbad++;
        end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL ign_tx: %0d clocks wrong, first clock %0d tx=%b want %b",
        nbad, fb, cap_tx[fb], exp_bit[fb/16]);
    end
    nbad = 0;
    for (int i = 0; i < n; i++)
      if (cap_done[i] !== exp_done[i]) begin
        if (nbad == 0) fb = i;
        nbad++;
      end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL ign_done: %0d clocks wrong, first clock %0d done=%b want %b",
        nbad, fb, cap_done[fb], exp_done[fb]);
    end
    tests++;
    if (cap_busy[n-1] !== 1'b0) begin
      fails++;
      $display("FAIL ign_busy_end: got %b want 0", cap_busy[n-1]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_random_stream();
    for (int k = 0; k < 3; k++) begin
      int n;
      int nbad = 0;
      int fb = 0;
      logic [7:0] bytes [3];
      for (int j = 0; j < 3; j++) bytes[j] = 8'($urandom);
      model_clear();
      for (int j = 0; j < 3; j++) model_frame(k, bytes[j]);
      n = exp_nbits * OVERSAMPLE + 1;
      write_now(k, bytes[0]);
      fork
        begin
          @(posedge clock);
          capture(k, n);
        end
        begin
          for (int j = 1; j < 3; j++) begin
            logic ok;
            wait_ready(k, 400, ok);
            if (!ok) begin
              tests++;
              fails++;
              $display("FAIL rnd%0d_ready_timeout: byte %0d", k, j);
              break;
            end
            write_now(k, bytes[j]);
          end
        end
      join
      for (int b = 0; b < exp_nbits; b++)
        for (int c = 0; c < OVERSAMPLE; c++)
          if (cap_tx[16*b+c] !== exp_bit[b]) begin
            if (nbad == 0) fb = 16*b + c;
            nbad++;
          end
      tests++;
      if (nbad != 0) begin
        fails++;
        $display("FAIL rnd%0d_tx: %0d clocks wrong, first clock %0d tx=%b want %b",
          k, nbad, fb, cap_tx[fb], exp_bit[fb/16]);
      end
      nbad = 0;
      for (int i = 0; i < n; i++)
        if (cap_done[i] !== exp_done[i]) begin
          if (nbad == 0) fb = i;
          nbad++;
        end
      tests++;
      if (nbad != 0) begin
        fails++;
        $display("FAIL rnd%0d_done: %0d clocks wrong, first clock %0d done=%b want %b",
          k, nbad, fb, cap_done[fb], exp_done[fb]);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d1;
    logic ok;
    int nbad = 0;
    d1 = 8'($urandom) & 8'hF7;
    write_now(0, d1);
    wait_ready(0, 4, ok);
    write_now(0, 8'($urandom));
    repeat (69) @(posedge clock);
    #3;
    tests++;
    if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0 || txl[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_pre: busy=%b ready=%b tx=%b want 1 0 0",
        bsy[0], rdy[0], txl[0]);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (txl[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_tx: got %b want 1", txl[0]);
    end
    tests++;
    if (rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: got %b want 1", rdy[0]);
    end
    tests++;
    if (bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy_done: busy=%b done=%b want 0 0", bsy[0], dn[0]);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) nbad++;
    end
    tests++;
    if (nbad != 0) begin
      fails++;
      $display("FAIL rst_no_frame: %0d active clocks after release, want 0", nbad);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_loopback();
    logic [7:0] lb [NLB];
    for (int j = 0; j < NLB; j++) lb[j] = 8'($urandom);
    fork
      begin
        for (int j = 0; j < NLB; j++) begin
          logic ok;
          wait_ready(0, 400, ok);
          if (!ok) begin
            tests++;
            fails++;
            $display("FAIL lb_ready_timeout: byte %0d", j);
            break;
          end
          write_now(0, lb[j]);
        end
      end
      begin
        for (int j = 0; j < NLB; j++) begin
          int w = 0;
          logic [7:0] rx;
          logic stop;
          @(negedge clock);
          while (txl[0] !== 1'b0 && w < 400) begin
            @(negedge clock);
            w++;
          end
          if (txl[0] !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL lb_start_timeout: byte %0d", j);
            break;
          end
          repeat (8) @(negedge clock);
          for (int b = 0; b < 8; b++) begin
            repeat (16) @(negedge clock);
            rx[b] = txl[0];
          end
          repeat (16) @(negedge clock);
          stop = txl[0];
          tests++;
          if (rx !== lb[j]) begin
            fails++;
            $display("FAIL lb_data: byte %0d got %h want %h", j, rx, lb[j]);
          end
          tests++;
          if (stop !== 1'b1) begin
            fails++;
            $display("FAIL lb_frame_error: byte %0d stop=%b want 1", j, stop);
          end
        end
      end
    join
    repeat (12) @(posedge clock);
    #1;
    tests++;
    if (bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || txl[0] !== 1'b1) begin
      fails++;
      $display("FAIL lb_idle: busy=%b ready=%b tx=%b want 0 1 1",
        bsy[0], rdy[0], txl[0]);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    wr      = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_parity();
    test_ignore_full();
    test_random_stream();
    test_reset_midframe();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
